// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache (read) and the
// D-cache (read / write-back). Latches the winning command, captures the L2
// read line, returns it with a one-cycle response pulse, and flags L2
// transactions that stall for too long.
module l2_rr_arbiter #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache side
  input  logic                  inst_rd_req,
  input  logic [15:0]           inst_address,
  output logic                  inst_resp,
  output logic [LINE_WIDTH-1:0] inst_rdata,
  // D-cache side
  input  logic                  data_rd_req,
  input  logic                  data_wr_req,
  input  logic [15:0]           data_address,
  input  logic [LINE_WIDTH-1:0] data_wdata,
  output logic                  data_resp,
  output logic [LINE_WIDTH-1:0] data_rdata,
  // L2 side
  output logic                  L2_read,
  output logic                  L2_write,
  output logic [15:0]           L2_address,
  output logic [LINE_WIDTH-1:0] L2_wdata,
  input  logic [LINE_WIDTH-1:0] L2_rdata,
  input  logic                  L2_resp,
  // Watchdog
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StGntI,
    StGntDrd,
    StGntDwr,
    StRespI,
    StRespD
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic                  last_d;       // 1: data was served last
  logic [15:0]           cmd_addr;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [7:0]            wd_cnt;
  logic                  timeout_q;

  logic inst_req;
  logic data_req;
  logic grant_inst;
  logic in_gnt;
  logic gnt_entry;
  logic wd_stall;
  logic wd_hit;

  // Arbitration and watchdog decode from current inputs and state
  always_comb begin
    inst_req   = inst_rd_req;
    data_req   = data_rd_req | data_wr_req;
    // Inst wins when alone, or on a tie when data went last
    grant_inst = inst_req & (~data_req | last_d);
    in_gnt     = (state_q == StGntI) || (state_q == StGntDrd) || (state_q == StGntDwr);
    gnt_entry  = (state_q == StIdle) && (inst_req || data_req);
    wd_stall   = in_gnt && !L2_resp;
    // Fires on the stall cycle that brings the count up to TIMEOUT
    wd_hit     = wd_stall && (wd_cnt >= (TimeoutCnt - 8'd1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant_inst) begin
          state_d = StGntI;
        end else if (data_wr_req) begin
          // Write-back precedes fill when both data requests are high
          state_d = StGntDwr;
        end else if (data_rd_req) begin
          state_d = StGntDrd;
        end
      end
      StGntI: begin
        if (L2_resp) state_d = StRespI;
      end
      StGntDrd, StGntDwr: begin
        if (L2_resp) state_d = StRespD;
      end
      StRespI, StRespD: begin
        // L2_resp is ignored here so a long response is consumed once
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    L2_read   = 1'b0;
    L2_write  = 1'b0;
    inst_resp = 1'b0;
    data_resp = 1'b0;
    case (state_q)
      StGntI, StGntDrd: L2_read   = 1'b1;
      StGntDwr:         L2_write  = 1'b1;
      StRespI:          inst_resp = 1'b1;
      StRespD:          data_resp = 1'b1;
      default: ;
    endcase
  end

  assign L2_address  = cmd_addr;
  assign L2_wdata    = wdata_q;
  assign inst_rdata  = rdata_q;
  assign data_rdata  = rdata_q;
  assign timeout_err = timeout_q;

  // Command latch: captured once on grant, stable for the whole transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_addr <= '0;
      wdata_q  <= '0;
    end else if (gnt_entry) begin
      cmd_addr <= grant_inst ? inst_address : data_address;
      if (!grant_inst && data_wr_req) begin
        wdata_q <= data_wdata;
      end
    end
  end

  // Capture the L2 read line on the completing grant cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (in_gnt && L2_resp) begin
      rdata_q <= L2_rdata;
    end
  end

  // Round-robin history, updated when the response is delivered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d <= 1'b1;
    end else if (state_q == StRespI) begin
      last_d <= 1'b0;
    end else if (state_q == StRespD) begin
      last_d <= 1'b1;
    end
  end

  // Watchdog counter: cleared on grant entry, saturates at TIMEOUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (gnt_entry) begin
      wd_cnt <= '0;
    end else if (wd_stall && (wd_cnt < TimeoutCnt)) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; the stalled transaction keeps waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (wd_hit) begin
      timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Self-checking bench for l2_rr_arbiter: directed scenarios plus randomized
// transactions, all checked against a transaction-level reference model.
module tb_l2_rr_arbiter;

  localparam int unsigned LW = 128;
  localparam int unsigned TO = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inst_rd_req = 1'b0;
  logic [15:0]   inst_address = '0;
  logic          inst_resp;
  logic [LW-1:0] inst_rdata;
  logic          data_rd_req = 1'b0;
  logic          data_wr_req = 1'b0;
  logic [15:0]   data_address = '0;
  logic [LW-1:0] data_wdata = '0;
  logic          data_resp;
  logic [LW-1:0] data_rdata;
  logic          L2_read;
  logic          L2_write;
  logic [15:0]   L2_address;
  logic [LW-1:0] L2_wdata;
  logic [LW-1:0] L2_rdata = '0;
  logic          L2_resp = 1'b0;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: who went last, last written line, sticky error
  logic          m_last_d = 1'b1;
  logic [LW-1:0] m_wdata = '0;
  logic          m_err = 1'b0;

  l2_rr_arbiter #(.LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_rd_req  (inst_rd_req),
    .inst_address (inst_address),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .data_rd_req  (data_rd_req),
    .data_wr_req  (data_wr_req),
    .data_address (data_address),
    .data_wdata   (data_wdata),
    .data_resp    (data_resp),
    .data_rdata   (data_rdata),
    .L2_read      (L2_read),
    .L2_write     (L2_write),
    .L2_address   (L2_address),
    .L2_wdata     (L2_wdata),
    .L2_rdata     (L2_rdata),
    .L2_resp      (L2_resp),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_rd_req = 1'b0;
    data_rd_req = 1'b0;
    data_wr_req = 1'b0;
    L2_resp = 1'b0;
    step();
    step();
    reset = 1'b0;
    m_last_d = 1'b1;
    m_wdata = '0;
    m_err = 1'b0;
  endtask

  // One full transaction from an IDLE cycle; delay = grant cycles before L2_resp
  task automatic run_txn(input logic i_req, input logic [15:0] i_addr, input logic d_rd,
                         input logic d_wr, input logic [15:0] d_addr, input logic [LW-1:0] wd,
                         input int delay, input int resp_len, input logic [LW-1:0] rd,
                         input logic scramble, input string name);
    logic        exp_inst;
    logic        exp_wr;
    logic [15:0] exp_addr;
    int          high;
    exp_inst = i_req && (!(d_rd || d_wr) || m_last_d);
    exp_wr   = !exp_inst && d_wr;
    exp_addr = exp_inst ? i_addr : d_addr;
    if (exp_wr) m_wdata = wd;
    inst_rd_req  = i_req;
    inst_address = i_addr;
    data_rd_req  = d_rd;
    data_wr_req  = d_wr;
    data_address = d_addr;
    data_wdata   = wd;
    L2_resp      = 1'b0;
    checks++;
    if ({L2_read, L2_write, inst_resp, data_resp} !== 4'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: got %b want 0000", name,
               {L2_read, L2_write, inst_resp, data_resp});
    end
    step();
    high = 0;
    for (int c = 0; c <= delay; c++) begin
      checks++;
      if ({L2_read, L2_write} !== {!exp_wr, exp_wr}) begin
        errors++;
        $display("FAIL %s grant_cmd cyc%0d: got rd/wr %b%b want %b%b", name, c, L2_read,
                 L2_write, !exp_wr, exp_wr);
      end
      checks++;
      if (L2_address !== exp_addr) begin
        errors++;
        $display("FAIL %s grant_addr cyc%0d: got %h want %h", name, c, L2_address, exp_addr);
      end
      checks++;
      if (L2_wdata !== m_wdata) begin
        errors++;
        $display("FAIL %s grant_wdata cyc%0d: got %h want %h", name, c, L2_wdata, m_wdata);
      end
      checks++;
      if ({inst_resp, data_resp} !== 2'b00) begin
        errors++;
        $display("FAIL %s grant_resp cyc%0d: got %b want 00", name, c, {inst_resp, data_resp});
      end
      if (L2_read || L2_write) high++;
      if (scramble) begin
        inst_address = 16'($urandom);
        data_address = 16'($urandom);
        data_wdata   = rand_line();
      end
      if (c == delay) begin
        L2_resp  = 1'b1;
        L2_rdata = rd;
      end else begin
        L2_rdata = rand_line();
      end
      step();
      if (c < delay && (c + 1) >= int'(TO)) m_err = 1'b1;
      checks++;
      if (timeout_err !== m_err) begin
        errors++;
        $display("FAIL %s timeout_err cyc%0d: got %b want %b", name, c, timeout_err, m_err);
      end
    end
    // Response cycle
    checks++;
    if (high != delay + 1) begin
      errors++;
      $display("FAIL %s cmd_cycles: got %0d want %0d", name, high, delay + 1);
    end
    checks++;
    if ({L2_read, L2_write, inst_resp, data_resp} !== {2'b00, exp_inst, !exp_inst}) begin
      errors++;
      $display("FAIL %s resp_pulse: got %b want %b", name, {L2_read, L2_write, inst_resp,
               data_resp}, {2'b00, exp_inst, !exp_inst});
    end
    checks++;
    if ((exp_inst ? inst_rdata : data_rdata) !== rd) begin
      errors++;
      $display("FAIL %s resp_rdata: got %h want %h", name,
               exp_inst ? inst_rdata : data_rdata, rd);
    end
    if (resp_len < 2) L2_resp = 1'b0;
    if (exp_inst) begin
      inst_rd_req = 1'b0;
    end else begin
      data_rd_req = 1'b0;
      data_wr_req = 1'b0;
    end
    m_last_d = !exp_inst;
    step();
    L2_resp = 1'b0;
    checks++;
    if ({L2_read, L2_write, inst_resp, data_resp} !== 4'b0) begin
      errors++;
      $display("FAIL %s after_resp: got %b want 0000", name,
               {L2_read, L2_write, inst_resp, data_resp});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({L2_read, L2_write, inst_resp, data_resp, timeout_err} !== 5'b0 ||
        L2_address !== 16'h0 || L2_wdata !== '0 || inst_rdata !== '0 || data_rdata !== '0) begin
      errors++;
      $display("FAIL reset_values: got ctl %b addr %h", {L2_read, L2_write, inst_resp,
               data_resp, timeout_err}, L2_address);
    end
    step();
    reset = 1'b0;
    data_wr_req  = 1'b1;
    data_address = 16'hBEEF;
    data_wdata   = rand_line();
    step();
    checks++;
    if (L2_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_write: got %b want 1", L2_write);
    end
    step();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (L2_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_drop: got %b want 0", L2_write);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_wr_req = 1'b0;
    m_last_d = 1'b1;
    m_wdata = '0;
    m_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({L2_read, L2_write, inst_resp, data_resp, timeout_err} !== 5'b0 ||
          L2_address !== 16'h0 || L2_wdata !== '0 || inst_rdata !== '0) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: got ctl %b addr %h", i, {L2_read, L2_write,
                 inst_resp, data_resp, timeout_err}, L2_address);
      end
    end
  endtask

  task automatic test_single_iread();
    run_txn(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 3, 1, {16{8'hA5}}, 1'b0, "single_iread");
  endtask

  task automatic test_contended();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, rand_line(), int'($urandom_range(0, 2)),
              1, rand_line(), 1'b0, "contended");
    end
  endtask

  task automatic test_writeback();
    run_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h4440, {8{16'h1122}}, 3, 1, rand_line(), 1'b1,
            "writeback");
  endtask

  task automatic test_rd_wr_both();
    run_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h7770, rand_line(), 1, 2, rand_line(), 1'b0,
            "rd_wr_both");
  endtask

  task automatic test_random();
    logic        ir;
    logic [1:0]  dk;
    for (int i = 0; i < 24; i++) begin
      ir = 1'($urandom);
      dk = 2'($urandom);
      if (!ir && dk == 2'b00) ir = 1'b1;
      run_txn(ir, 16'($urandom), dk[0], dk[1], 16'($urandom), rand_line(),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 2)), rand_line(),
              1'($urandom), "random");
    end
  endtask

  task automatic test_watchdog();
    run_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h5550, '0, 8, 1, rand_line(), 1'b0, "watchdog");
    run_txn(1'b1, 16'h6660, 1'b0, 1'b0, 16'h0, '0, 0, 1, rand_line(), 1'b0, "watchdog_after");
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_reset_clear: got %b want 0", timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_iread();
    test_contended();
    test_writeback();
    test_rd_wr_both();
    test_random();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running, want finished");
    $fatal(1, "time limit");
  end

endmodule
